imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the instruction memory and the CPU core.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them to sequential word addresses of instruction memory.
- Holds the core in reset until the image is complete, then releases it so fetch starts at PC 0 with the program already present.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; legal range 1..16; MAX_WORDS = 2**ADDR_W (derived, not overridable).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to reload; honoured only in DONE or ERR
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream payload
- in_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  ADDR_W  word address for the write
- imem_wdata  out  32  assembled instruction word
- cpu_reset_n  out  1  active-low reset to the core; 0 while loading
- load_done  out  1  image loaded, core released
- err  out  1  illegal word count received
- words_loaded  out  17  number of words written since the last load start

Behaviour:
- Reset (reset=0, async): state=CNT_LO, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset_n=0, load_done=0, err=0, words_loaded=0; byte index=0, count register=0, partial word discarded.
- Byte accepted on a rising edge where in_valid && in_ready.
- in_ready=1 only in CNT_LO, CNT_HI, DATA. It is 0 in FLUSH, DONE and ERR, and combinationally derived from state.
- Stream format: 2-byte word count N (LSB first), then 4*N data bytes. Each word is LSB first: wdata = {b3,b2,b1,b0}.
- CNT_LO: accept byte -> N[7:0], go CNT_HI.
- CNT_HI: accept byte -> N[15:8]. Using the full 16-bit N:
  - N==0: go DONE.
  - N>MAX_WORDS: go ERR.
  - otherwise: go DATA.
- DATA: 2-bit byte index counts 0..3 and wraps.
  - On acceptance of byte 3 of word k, the next cycle has imem_we=1, imem_addr=k[ADDR_W-1:0], imem_wdata=assembled word; words_loaded increments in that same cycle.
  - imem_we is registered and pulses exactly one cycle per word. Back-to-back words with in_valid held high give one write every 4 cycles; in_ready stays 1 during non-final write pulses.
  - On the byte completing word N-1, go FLUSH.
- FLUSH: one cycle carrying the final imem_we pulse; in_ready=0; then go DONE.
- DONE: load_done=1 and cpu_reset_n=1, both registered.
  - They first assert the cycle after the final write pulse, or the cycle after the CNT_HI acceptance when N==0.
- ERR: err=1, cpu_reset_n=0, load_done=0, no writes.
- start in DONE/ERR: next state CNT_LO. Next cycle: load_done=0, cpu_reset_n=0, err=0, words_loaded=0, byte index=0, imem_addr=0.
- start in any other state is ignored. in_valid outside in_ready=1 states is ignored; no byte is consumed.
- Address wrap impossible: N<=MAX_WORDS guarantees k<MAX_WORDS; N==MAX_WORDS writes the last address 2**ADDR_W-1.
- Simultaneous start and in_valid in DONE: start wins; the byte is not accepted that cycle (in_ready=0).
- Reset asserted mid-load: immediate return to reset values; the core stays in reset; any partially written image is not cleaned up and is simply overwritten by the next load.
- No outputs other than in_ready are combinational.

Test Plan:
- Reset release then bytes 02 00 | 13 00 50 00 | 93 00 10 00 with in_valid always 1 -> writes addr0=0x00500013, addr1=0x00100093, one imem_we cycle each, 4 cycles apart; words_loaded=2; load_done=1, cpu_reset_n=1 the cycle after the second pulse; in_ready=0 afterwards.
- Same image with in_valid toggled randomly (50%) -> identical writes and data; no extra or missing imem_we pulses; bytes during in_valid=0 are not consumed.
- Count bytes 00 00 -> no imem_we; load_done=1 the cycle after the second byte accepted; words_loaded=0.
- ADDR_W=8, count 01 01 (N=257) -> err=1, cpu_reset_n=0, in_ready=0, no writes. Then start=1 and count 00 01 plus 1024 bytes -> 256 writes; last at addr 0xFF; load_done=1.
- In DONE, start=1 -> next cycle load_done=0, cpu_reset_n=0, words_loaded=0. A new 1-word image overwrites addr0.
- reset=0 asserted after 6 data bytes -> all outputs at reset values within the same cycle (async). After release, a full 1-word image loads cleanly at addr0 with no stale bytes.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: turns a byte stream (16-bit word count N, then 4*N bytes, LSB first) into instruction-memory writes.
// Latency: write strobe one cycle after the fourth byte of a word; core released the cycle after the final write.
// Backpressure: in_ready is high only while a count or data byte is expected; it is low in FLUSH, DONE and ERR.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset_n,
    output logic              load_done,
    output logic              err,
    output logic [16:0]       words_loaded
);

    localparam int          MAX_WORDS = 2 ** ADDR_W;
    localparam logic [16:0] MAX_W17   = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        FLUSH,
        DONE,
        ERR
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;       // word count N from the header
    logic [1:0]  byte_idx_q;  // byte position inside the current word
    logic [23:0] buf_q;       // bytes 0..2 of the word being assembled
    logic [15:0] word_idx_q;  // index k of the word being assembled
    logic        accept;
    logic        last_word;
    logic [15:0] n_full;
    logic        reload;

    assign accept    = in_valid && in_ready;
    assign last_word = (word_idx_q == cnt_q - 16'd1);
    assign n_full    = {in_data, cnt_q[7:0]};
    assign reload    = start && (state_q == DONE || state_q == ERR);

    // Next-state decode and the only combinational output, in_ready.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            CNT_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_d = CNT_HI;
            end
            CNT_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (n_full == 16'd0)                state_d = DONE;
                    else if ({1'b0, n_full} > MAX_W17)  state_d = ERR;
                    else                                state_d = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (in_valid && byte_idx_q == 2'd3 && last_word) state_d = FLUSH;
            end
            FLUSH: state_d = DONE;
            DONE:  if (start) state_d = CNT_LO;
            ERR:   if (start) state_d = CNT_LO;
            default: state_d = CNT_LO;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= CNT_LO;
        else        state_q <= state_d;
    end

    // Word assembly, write strobe and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            byte_idx_q   <= '0;
            buf_q        <= '0;
            word_idx_q   <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            load_done    <= 1'b0;
            cpu_reset_n  <= 1'b0;
            err          <= 1'b0;
        end else begin
            imem_we     <= 1'b0;
            // Status follows the state being entered so it lines up with it.
            load_done   <= (state_d == DONE);
            cpu_reset_n <= (state_d == DONE);
            err         <= (state_d == ERR);

            if (accept && state_q == CNT_LO) cnt_q[7:0]  <= in_data;
            if (accept && state_q == CNT_HI) cnt_q[15:8] <= in_data;

            if (accept && state_q == DATA) begin
                byte_idx_q <= byte_idx_q + 2'd1;
                case (byte_idx_q)
                    2'd0: buf_q[7:0]   <= in_data;
                    2'd1: buf_q[15:8]  <= in_data;
                    2'd2: buf_q[23:16] <= in_data;
                    default: begin
                        imem_we      <= 1'b1;
                        imem_addr    <= word_idx_q[ADDR_W-1:0];
                        imem_wdata   <= {in_data, buf_q};
                        words_loaded <= words_loaded + 17'd1;
                        word_idx_q   <= word_idx_q + 16'd1;
                    end
                endcase
            end

            // Reload request: restart the stream parser from a clean slate.
            if (reload) begin
                cnt_q        <= '0;
                byte_idx_q   <= '0;
                word_idx_q   <= '0;
                imem_addr    <= '0;
                words_loaded <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: drives byte images and scores every memory write against a queue of expected writes.
// Latency: writes are captured on the falling edge and matched in order after each image completes.
// Backpressure: bytes are only counted as sent once in_ready was seen high before the accepting edge.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset_n;
    logic              load_done;
    logic              err;
    logic [16:0]       words_loaded;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset_n(cpu_reset_n), .load_done(load_done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [16:0]       wl;
        int                cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  rd = 0;
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;

    // Write monitor: logs every strobe seen on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (imem_we === 1'b1)
            obs_q.push_back('{addr: imem_addr, data: imem_wdata, wl: words_loaded, cyc: cyc});
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int guard = 0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            $display("FAIL send_timeout in_ready=%b required 1 byte=%h", in_ready, b);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], rnd);
    endtask

    task automatic expect_write(input int k, input logic [31:0] w);
        exp_q.push_back('{addr: ADDR_W'(k), data: w, wl: 17'(k + 1), cyc: 0});
    endtask

    task automatic do_start();
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #1;
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata, cpu_reset_n, load_done, err, words_loaded, in_ready} !==
            {1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 17'd0, 1'b1})
            $display("FAIL reset_state we=%b addr=%h wdata=%h crn=%b done=%b err=%b wl=%0d rdy=%b required 0,0,0,0,0,0,0,1",
                     imem_we, imem_addr, imem_wdata, cpu_reset_n, load_done, err, words_loaded, in_ready);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] img [10];
        int base;
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        expect_write(0, 32'h00500013);
        expect_write(1, 32'h00100093);
        base = rd;
        for (int i = 0; i < 10; i++) send_byte(img[i], 1'b0);
        n_checks++;
        if (load_done !== 1'b0 || in_ready !== 1'b0 || imem_we !== 1'b1)
            $display("FAIL basic_flush done=%b rdy=%b we=%b required 0,0,1", load_done, in_ready, imem_we);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (load_done !== 1'b1 || cpu_reset_n !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0)
            $display("FAIL basic_done done=%b crn=%b rdy=%b we=%b required 1,1,0,0", load_done, cpu_reset_n, in_ready, imem_we);
        else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++;
        if (obs_q.size() - base !== 2 || words_loaded !== 17'd2)
            $display("FAIL basic_count writes=%0d wl=%0d required 2,2", obs_q.size() - base, words_loaded);
        else n_pass++;
        if (obs_q.size() - base >= 2) begin
            n_checks++;
            if (obs_q[base+1].cyc - obs_q[base].cyc !== 4)
                $display("FAIL basic_gap gap=%0d required 4", obs_q[base+1].cyc - obs_q[base].cyc);
            else n_pass++;
        end
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            wr_t e; wr_t o;
            e = exp_q.pop_front(); o = obs_q[rd]; rd++;
            n_checks++;
            if (o.addr !== e.addr || o.data !== e.data || o.wl !== e.wl)
                $display("FAIL basic_write addr=%h data=%h wl=%0d required %h %h %0d", o.addr, o.data, o.wl, e.addr, e.data, e.wl);
            else n_pass++;
        end
        exp_q.delete(); rd = obs_q.size();
        in_valid = 1'b0;
    endtask

    task automatic test_random_valid();
        do_start();
        expect_write(0, 32'h00500013);
        expect_write(1, 32'h00100093);
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_word(32'h00500013, 1'b1);
        send_word(32'h00100093, 1'b1);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (load_done !== 1'b1 || obs_q.size() - rd !== 2)
            $display("FAIL rand_done done=%b writes=%0d required 1,2", load_done, obs_q.size() - rd);
        else n_pass++;
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            wr_t e; wr_t o;
            e = exp_q.pop_front(); o = obs_q[rd]; rd++;
            n_checks++;
            if (o.addr !== e.addr || o.data !== e.data || o.wl !== e.wl)
                $display("FAIL rand_write addr=%h data=%h wl=%0d required %h %h %0d", o.addr, o.data, o.wl, e.addr, e.data, e.wl);
            else n_pass++;
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    task automatic test_zero_count();
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if (load_done !== 1'b1 || cpu_reset_n !== 1'b1 || words_loaded !== 17'd0)
            $display("FAIL zero_done done=%b crn=%b wl=%0d required 1,1,0", load_done, cpu_reset_n, words_loaded);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== rd)
            $display("FAIL zero_nowrite writes=%0d required 0", obs_q.size() - rd);
        else n_pass++;
    endtask

    task automatic test_err_then_full();
        logic [31:0] w;
        int base;
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        n_checks++;
        if (err !== 1'b1 || cpu_reset_n !== 1'b0 || in_ready !== 1'b0 || load_done !== 1'b0)
            $display("FAIL err_state err=%b crn=%b rdy=%b done=%b required 1,0,0,0", err, cpu_reset_n, in_ready, load_done);
        else n_pass++;
        in_data = 8'hA5;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== rd || err !== 1'b1)
            $display("FAIL err_nowrite writes=%0d err=%b required 0,1", obs_q.size() - rd, err);
        else n_pass++;
        do_start();
        n_checks++;
        if (err !== 1'b0 || load_done !== 1'b0 || words_loaded !== 17'd0 || in_ready !== 1'b1)
            $display("FAIL err_restart err=%b done=%b wl=%0d rdy=%b required 0,0,0,1", err, load_done, words_loaded, in_ready);
        else n_pass++;
        base = rd;
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        for (int k = 0; k < 256; k++) begin
            w = $urandom;
            expect_write(k, w);
            send_word(w, 1'b0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (load_done !== 1'b1 || words_loaded !== 17'd256 || obs_q.size() - base !== 256)
            $display("FAIL full_done done=%b wl=%0d writes=%0d required 1,256,256", load_done, words_loaded, obs_q.size() - base);
        else n_pass++;
        if (obs_q.size() > base) begin
            n_checks++;
            if (obs_q[obs_q.size()-1].addr !== 8'hFF)
                $display("FAIL full_last_addr addr=%h required ff", obs_q[obs_q.size()-1].addr);
            else n_pass++;
        end
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            wr_t e; wr_t o;
            e = exp_q.pop_front(); o = obs_q[rd]; rd++;
            n_checks++;
            if (o.addr !== e.addr || o.data !== e.data || o.wl !== e.wl)
                $display("FAIL full_write addr=%h data=%h wl=%0d required %h %h %0d", o.addr, o.data, o.wl, e.addr, e.data, e.wl);
            else n_pass++;
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    task automatic test_restart();
        // start and a valid byte together in DONE: the byte must not be taken
        start = 1'b1; in_valid = 1'b1; in_data = 8'h05;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (load_done !== 1'b0 || cpu_reset_n !== 1'b0 || words_loaded !== 17'd0 || imem_addr !== 8'h00 || in_ready !== 1'b1)
            $display("FAIL restart_clear done=%b crn=%b wl=%0d addr=%h rdy=%b required 0,0,0,00,1",
                     load_done, cpu_reset_n, words_loaded, imem_addr, in_ready);
        else n_pass++;
        expect_write(0, 32'hDEADBEEF);
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_word(32'hDEADBEEF, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (load_done !== 1'b1 || obs_q.size() - rd !== 1)
            $display("FAIL restart_done done=%b writes=%0d required 1,1", load_done, obs_q.size() - rd);
        else n_pass++;
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            wr_t e; wr_t o;
            e = exp_q.pop_front(); o = obs_q[rd]; rd++;
            n_checks++;
            if (o.addr !== e.addr || o.data !== e.data || o.wl !== e.wl)
                $display("FAIL restart_write addr=%h data=%h wl=%0d required %h %h %0d", o.addr, o.data, o.wl, e.addr, e.data, e.wl);
            else n_pass++;
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    task automatic test_midload_reset();
        do_start();
        expect_write(0, 32'h11223344);
        send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
        send_word(32'h11223344, 1'b0);
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata, cpu_reset_n, load_done, err, words_loaded} !==
            {1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 17'd0})
            $display("FAIL midload_reset we=%b addr=%h wdata=%h crn=%b done=%b err=%b wl=%0d required all 0",
                     imem_we, imem_addr, imem_wdata, cpu_reset_n, load_done, err, words_loaded);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        expect_write(0, 32'hCAFEF00D);
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (load_done !== 1'b1 || cpu_reset_n !== 1'b1 || words_loaded !== 17'd1)
            $display("FAIL midload_done done=%b crn=%b wl=%0d required 1,1,1", load_done, cpu_reset_n, words_loaded);
        else n_pass++;
        n_checks++;
        if (obs_q.size() - rd !== 2)
            $display("FAIL midload_count writes=%0d required 2", obs_q.size() - rd);
        else n_pass++;
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            wr_t e; wr_t o;
            e = exp_q.pop_front(); o = obs_q[rd]; rd++;
            n_checks++;
            if (o.addr !== e.addr || o.data !== e.data || o.wl !== e.wl)
                $display("FAIL midload_write addr=%h data=%h wl=%0d required %h %h %0d", o.addr, o.data, o.wl, e.addr, e.data, e.wl);
            else n_pass++;
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_valid();
        test_zero_count();
        test_err_then_full();
        test_restart();
        test_midload_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
